buf_read_streamer: RTL and testbench

//  Read-side master for the ACT/WEI/PSUM scratchpad buffers. Accepts one strided burst command, drives the buffer's

---
 rtl/buf_read_streamer_pkg.sv | 15 +
 rtl/buf_read_streamer_fifo.sv | 57 +++++
 rtl/buf_read_streamer.sv | 150 +++++++++++++++
 tb/tb_buf_read_streamer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/buf_read_streamer_pkg.sv
// Shared widths and FSM encoding for the scratchpad read streamer.
package buf_read_streamer_pkg;

    localparam int ACT_BUF_DATA      = 64;
    localparam int ACT_BUF_ROWS_LOG2 = 8;
    localparam int BRS_LEN_W         = 9;
    localparam int BRS_FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } brs_state_e;

endpackage

// File: rtl/buf_read_streamer_fifo.sv
// Small synchronous FIFO with occupancy count and flush, used to absorb
// downstream backpressure behind the buffer read port.
module stream_fifo
    import buf_read_streamer_pkg::*;
#(
    parameter int W     = ACT_BUF_DATA + 1,
    parameter int DEPTH = BRS_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [W-1:0]           wdata,
    output logic [W-1:0]           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign empty  = (count_q == '0);
    assign do_pop = pop && !empty;
    assign rdata  = mem_q[rptr_q];
    assign count  = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wdata;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/buf_read_streamer.sv
// Strided burst reader: issues buffer reads under FIFO credit control and
// streams the returned words out over a valid/ready port.
module buf_read_streamer
    import buf_read_streamer_pkg::*;
#(
    parameter int DATA_W     = ACT_BUF_DATA,
    parameter int ADDR_W     = ACT_BUF_ROWS_LOG2,
    parameter int LEN_W      = BRS_LEN_W,
    parameter int FIFO_DEPTH = BRS_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    brs_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;

    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [DATA_W:0]   fifo_rdata;
    logic              kill;
    logic              pop;
    logic              push;
    logic              room;
    logic [CW-1:0]     occ;

    assign kill      = abort && (state_q != ST_IDLE);
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = rd_en_q && !kill;
    // Occupancy once this edge's capture and pop have both landed.
    assign occ       = fifo_count + CW'(rd_en_q) - CW'(pop);
    assign room      = occ < CW'(FIFO_DEPTH);

    assign buf_rd_en   = rd_en_q;
    assign buf_rd_addr = rd_addr_q;
    assign out_data    = fifo_rdata[DATA_W-1:0];
    assign out_last    = fifo_rdata[DATA_W] && out_valid;
    assign done        = done_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        rem_d     = rem_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = 1'b0;
        rd_last_d = 1'b0;
        done_d    = 1'b0;
        cmd_ready = (state_q == ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = ST_ISSUE;
                        addr_d   = cmd_base;
                        stride_d = cmd_stride;
                        rem_d    = cmd_len;
                    end
                end
            end
            ST_ISSUE: begin
                if (!kill && room) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = addr_q;
                    rd_last_d = (rem_q == LEN_W'(1));
                    addr_d    = addr_q + stride_q;
                    rem_d     = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_en_q && occ == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (kill) begin
            state_d   = ST_IDLE;
            rd_en_d   = 1'b0;
            rd_last_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            stride_q  <= '0;
            rem_q     <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            stride_q  <= stride_d;
            rem_q     <= rem_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            rd_last_q <= rd_last_d;
            done_q    <= done_d;
        end
    end

    stream_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (kill),
        .wdata ({rd_last_q, buf_rd_data}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_buf_read_streamer.sv
// Randomized directed bench for buf_read_streamer against an arithmetic
// reference of the strided burst and a negedge stream monitor.
module tb_buf_read_streamer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_base;
    logic [7:0]  cmd_stride;
    logic [8:0]  cmd_len;
    logic        abort;
    logic        buf_rd_en;
    logic [7:0]  buf_rd_addr;
    logic [63:0] buf_rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        done;

    logic [63:0] mem [256];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] rx_data [$];
    logic        rx_last [$];
    logic [7:0]  addr_log [$];
    int n_issued, n_done, n_valid, n_last_hi, max_out, stab_err;
    int first_valid_cyc, first_pop_cyc, last_pop_cyc, done_cyc;
    logic        prev_hold;
    logic [63:0] prev_d;
    logic        prev_l;

    buf_read_streamer dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_base    (cmd_base),
        .cmd_stride  (cmd_stride),
        .cmd_len     (cmd_len),
        .abort       (abort),
        .buf_rd_en   (buf_rd_en),
        .buf_rd_addr (buf_rd_addr),
        .buf_rd_data (buf_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .done        (done)
    );

    assign buf_rd_data = mem[buf_rd_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (buf_rd_en) begin
                addr_log.push_back(buf_rd_addr);
                n_issued++;
            end
            if (n_issued - rx_data.size() > max_out) max_out = n_issued - rx_data.size();
            if (prev_hold && !(out_valid && out_data === prev_d && out_last === prev_l))
                stab_err++;
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            prev_l    = out_last;
            if (out_valid) begin
                n_valid++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (out_last) n_last_hi++;
            if (out_valid && out_ready) begin
                rx_data.push_back(out_data);
                rx_last.push_back(out_last);
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
            end
            if (done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rx_data.delete();
        rx_last.delete();
        addr_log.delete();
        n_issued = 0; n_done = 0; n_valid = 0; n_last_hi = 0;
        max_out = 0; stab_err = 0; prev_hold = 1'b0;
        first_valid_cyc = -1; first_pop_cyc = -1;
        last_pop_cyc = -1; done_cyc = -1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_cmd(input logic [7:0] base, input logic [7:0] stride,
                             input int len, output int acc_cyc);
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_stride = stride;
        cmd_len    = 9'(len);
        acc_cyc    = cyc + 1;
        tick(1);
        cmd_valid  = 1'b0;
    endtask

    // rmode: 0 = ready held high, 1 = random ready; hold = leading stall cycles
    task automatic run_burst(input string tag, input logic [7:0] base, input logic [7:0] stride,
                             input int len, input int rmode, input int hold);
        logic [63:0] exp_d [$];
        logic [7:0]  exp_a [$];
        int acc_cyc, budget, derr, lerr, aerr;
        for (int k = 0; k < len; k++) begin
            exp_a.push_back(8'((int'(base) + k * int'(stride)) % 256));
            exp_d.push_back(mem[exp_a[k]]);
        end
        clear_logs();
        out_ready = (hold > 0) ? 1'b0 : 1'b1;
        start_cmd(base, stride, len, acc_cyc);
        budget = 0;
        while (n_done == 0 && budget < 5000) begin
            if (budget < hold) out_ready = 1'b0;
            else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
            else out_ready = 1'b1;
            tick(1);
            budget++;
            if (hold > 0 && budget == hold) begin
                chk({tag, "_stall_reads"}, n_issued, 4);
                chk({tag, "_stall_rd_en"}, buf_rd_en, 0);
            end
        end
        chk({tag, "_timeout"}, budget < 5000, 1);
        out_ready = 1'b1;
        tick(3);
        derr = 0; lerr = 0; aerr = 0;
        chk({tag, "_nwords"}, rx_data.size(), len);
        for (int i = 0; i < rx_data.size() && i < len; i++) begin
            if (rx_data[i] !== exp_d[i]) derr++;
            if (rx_last[i] !== (i == len - 1)) lerr++;
        end
        chk({tag, "_data_err"}, derr, 0);
        chk({tag, "_last_err"}, lerr, 0);
        chk({tag, "_nreads"}, addr_log.size(), len);
        for (int i = 0; i < addr_log.size() && i < len; i++)
            if (addr_log[i] !== exp_a[i]) aerr++;
        chk({tag, "_addr_err"}, aerr, 0);
        chk({tag, "_done_cnt"}, n_done, 1);
        chk({tag, "_credit"}, max_out <= 4, 1);
        chk({tag, "_stable"}, stab_err, 0);
        if (rmode == 0 && hold == 0) begin
            chk({tag, "_start_lat"}, first_valid_cyc - acc_cyc, 2);
            chk({tag, "_thruput"}, last_pop_cyc - first_pop_cyc, len - 1);
            chk({tag, "_done_lat"}, done_cyc - last_pop_cyc, 1);
        end
    endtask

    int acc, snap, budget;
    logic [7:0] rb, rs;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        rst = 1'b1; cmd_valid = 1'b0; cmd_base = '0; cmd_stride = '0;
        cmd_len = '0; abort = 1'b0; out_ready = 1'b0;
        clear_logs();
        tick(3);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rd_en", buf_rd_en, 0);
        chk("rst_rd_addr", buf_rd_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick(2);

        run_burst("seq5", 8'h10, 8'h01, 5, 0, 0);
        run_burst("wrap4", 8'hFE, 8'h03, 4, 0, 0);
        run_burst("stall8", 8'h40, 8'h02, 8, 0, 20);
        rb = 8'($urandom); rs = 8'($urandom);
        run_burst("rand200", rb, rs, 200, 1, 0);
        run_burst("one", 8'h33, 8'h05, 1, 1, 0);

        // abort while the third word is presented
        clear_logs();
        out_ready = 1'b1;
        start_cmd(8'h80, 8'h01, 10, acc);
        budget = 0;
        while (!(out_valid && rx_data.size() == 2) && budget < 50) begin
            tick(1);
            budget++;
        end
        chk("abort_reach", budget < 50, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        snap = n_issued;
        chk("abort_rd_en", buf_rd_en, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done, 1);
        chk("abort_ready", cmd_ready, 1);
        tick(6);
        chk("abort_no_reads", n_issued, snap);
        chk("abort_done_cnt", n_done, 1);
        chk("abort_no_last", n_last_hi, 0);
        chk("abort_nwords", rx_data.size(), 3);
        for (int i = 0; i < rx_data.size(); i++)
            chk("abort_prefix", rx_data[i], mem[8'(8'h80 + i)]);
        run_burst("post_abort", 8'h20, 8'h04, 6, 0, 0);

        // abort while idle does nothing
        clear_logs();
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        tick(2);
        chk("idle_abort_done", n_done, 0);
        chk("idle_abort_ready", cmd_ready, 1);

        // zero-length command
        clear_logs();
        start_cmd(8'h05, 8'h01, 0, acc);
        chk("len0_done", done, 1);
        chk("len0_ready", cmd_ready, 1);
        tick(8);
        chk("len0_reads", n_issued, 0);
        chk("len0_valid", n_valid, 0);
        chk("len0_done_cnt", n_done, 1);

        // reset in the middle of a stalled burst
        clear_logs();
        out_ready = 1'b0;
        start_cmd(8'h60, 8'h01, 20, acc);
        tick(6);
        rst = 1'b1;
        #1;
        chk("mrst_cmd_ready", cmd_ready, 1);
        chk("mrst_rd_en", buf_rd_en, 0);
        chk("mrst_rd_addr", buf_rd_addr, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_out_last", out_last, 0);
        chk("mrst_done", done, 0);
        tick(2);
        rst = 1'b0;
        clear_logs();
        tick(4);
        chk("mrst_no_done", n_done, 0);
        run_burst("post_rst", 8'hC0, 8'hFF, 7, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
